psum_ofifo: RTL and testbench
=============================

Name: psum_ofifo

Overview:
- Output FIFO directly downstream of the MAC row.
- Captures each column's partial sum (out_s slice) on that column's valid strobe, whether strobes arrive together or skewed across cycles.
- Presents a complete psum row to the accumulation/SFU stage only once every column has at least one entry.
- One independent circular queue per column; all queues share one row-wide read.

Parameters:
- col, 8, number of columns (matches MAC row width).
- psum_bw, 32, width of one partial sum.
- depth, 64, entries per column queue; power of two, at least 2.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 at a rising edge clears state).
- in  input  psum_bw*col  psum row from MAC row; column i at bits [psum_bw*(i+1)-1 : psum_bw*i].
- wr  input  col  per-column write strobe (driven by MAC row valid[i]).
- rd  input  1  row read request from downstream.
- o_full  output  1  OR of all column-full flags.
- o_ready  output  1  equals ~o_full.
- o_valid  output  1  AND of all column-non-empty flags.
- out  output  psum_bw*col  registered popped row, same column packing as in.
- o_overflow  output  1  sticky: a write was dropped on a full column.
- o_underflow  output  1  sticky: rd asserted while o_valid==0.

Behaviour:
- Per-column storage:
  - depth x psum_bw array.
  - wptr and rptr, each log2(depth)+1 bits; the MSB is the wrap bit.
  - empty_i = (wptr==rptr).
  - full_i = low bits equal and MSBs differ.
- Reset (reset==0 at an edge):
  - All pointers = 0.
  - out = 0, o_overflow = 0, o_underflow = 0.
  - Array contents don't-care.
  - Combinational outputs after reset: o_full=0, o_ready=1, o_valid=0.
  - Reset dominates any wr/rd in the same cycle.
- Write, column i:
  - When wr[i]==1 and full_i==0 at the edge: mem_i[wptr_i] <= in slice i, wptr_i += 1 (modulo 2*depth).
  - When wr[i]==1 and full_i==1: data dropped, pointer unchanged, o_overflow <= 1.
  - Columns write independently; any subset of wr bits may be set in a cycle.
- Read:
  - When rd==1 and o_valid==1 at the edge: every column pops.
  - out slice i <= mem_i[rptr_i] and rptr_i += 1, for all i in the same edge.
  - out is valid starting the cycle after the accepting edge (1-cycle latency) and holds until the next accepted read.
  - When rd==1 and o_valid==0: no pop, out holds, o_underflow <= 1.
- Simultaneous write and read on the same column:
  - Both take effect.
  - full_i and o_valid are evaluated from pre-edge state.
  - A write to a full column is dropped even if a read pops that column in the same cycle.
  - A read needs o_valid==1 pre-edge, so a write into an empty column is never read the same cycle.
- Wrap-around: pointers wrap naturally; the MSB toggles each pass so full/empty stay unambiguous at every depth boundary.
- Status flags:
  - o_full, o_ready and o_valid are combinational from pointer state only; no dependence on wr or rd in the current cycle.
  - o_overflow and o_underflow clear only on reset.
- Skew: column i may hold more entries than column j. o_valid tracks the least-filled column, so a row is only read when all columns have a matching entry.
- Reset mid-operation: all stored entries are discarded. The first row after reset is the first set of writes after reset is released.

Test Plan:
- Reset, then write all 8 columns in one cycle with column i = 100+i, then rd -> o_valid rises the cycle after the write; one cycle after rd, out slice i = 100+i; o_valid falls back to 0.
- Skewed strobes: wr = one-hot 1<<k on cycles k=0..7, data 0xA0+k -> o_valid stays 0 until after the cycle-7 write, then 1; after a read, out = {0xA7,...,0xA0}.
- Fill one column: write column 0 64 times with values 0..63 and all others once -> o_full=1 and o_ready=0; a 65th write to column 0 sets o_overflow=1 and leaves the stored contents unchanged.
- Wrap: stream 200 full rows, data = row index, reading each row 1 cycle after its write -> out returns 0..199 in order; no overflow or underflow; pointers pass the depth boundary 3 times.
- Read with column 3 empty and others non-empty -> out unchanged, no pointer moves, o_underflow=1. Same-cycle wr+rd on a full column -> write dropped, read returns the oldest entry.
- Reset held low for 1 cycle with 10 rows stored -> o_valid=0, o_full=0, out=0, both flags 0; the next write of row 0x55 is the next row read.

Source files
------------

// File: rtl/psum_ofifo.sv
// psum_ofifo: per-column output FIFO behind the MAC row.
// Each column captures its partial sum on its own write strobe, so the
// strobes may arrive skewed. A whole row is popped once every column holds
// at least one entry. All columns share one row-wide read.
module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 32,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_overflow,
    output logic                   o_underflow
);

    // The extra pointer bit is the wrap bit. It tells full apart from empty
    // when the low address bits of the two pointers are equal.
    localparam int AW = $clog2(depth);

    logic [col-1:0] empty;
    logic [col-1:0] full;
    logic           pop;
    logic           ovf_q, ovf_d;
    logic           udf_q, udf_d;

    // Status comes only from the pre-edge pointers, never from wr or rd.
    assign o_full  = |full;
    assign o_ready = ~o_full;
    assign o_valid = &(~empty);
    assign pop     = rd & o_valid;

    for (genvar c = 0; c < col; c++) begin : g_col
        logic [psum_bw-1:0] mem_q [depth];
        logic [AW:0]        wptr_q, wptr_d;
        logic [AW:0]        rptr_q, rptr_d;
        logic [psum_bw-1:0] out_q, out_d;
        logic               push;

        assign empty[c] = (wptr_q == rptr_q);
        assign full[c]  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                          (wptr_q[AW] != rptr_q[AW]);
        // A write to a full column is dropped, even if this edge also pops it.
        assign push     = wr[c] & ~full[c];

        // Next-state for this column's pointers and popped output slice.
        always_comb begin
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            out_d  = out_q;
            if (push) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (pop) begin
                out_d  = mem_q[rptr_q[AW-1:0]];
                rptr_d = rptr_q + 1'b1;
            end
        end

        // Storage array. Its contents are don't-care after reset, so it has no reset.
        always_ff @(posedge clk) begin
            if (push) begin
                mem_q[wptr_q[AW-1:0]] <= in[c*psum_bw +: psum_bw];
            end
        end

        // Pointer and output registers, cleared by the synchronous reset.
        always_ff @(posedge clk) begin
            if (!reset) begin
                wptr_q <= '0;
                rptr_q <= '0;
                out_q  <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                out_q  <= out_d;
            end
        end

        assign out[c*psum_bw +: psum_bw] = out_q;
    end

    // Sticky error flags. They are cleared only by reset.
    always_comb begin
        ovf_d = ovf_q | (|(wr & full));
        udf_d = udf_q | (rd & ~o_valid);
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign o_overflow  = ovf_q;
    assign o_underflow = udf_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Self-checking bench for psum_ofifo. It keeps one reference queue per column.
// Writes push to the queues when they are driven. Accepted reads pop the queues
// into the expected output row, and that row is compared with out.
module tb_psum_ofifo;

    localparam int NC    = 8;
    localparam int BW    = 32;
    localparam int DEPTH = 64;

    logic              clk;
    logic              reset;
    logic [BW*NC-1:0]  in;
    logic [NC-1:0]     wr;
    logic              rd;
    logic              o_full, o_ready, o_valid;
    logic [BW*NC-1:0]  out;
    logic              o_overflow, o_underflow;

    int tests = 0;
    int fails = 0;

    logic [BW-1:0]    mq [NC][$];
    logic [BW*NC-1:0] exp_row;
    logic             exp_ovf;
    logic             exp_udf;

    psum_ofifo #(.col(NC), .psum_bw(BW), .depth(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in),
        .wr         (wr),
        .rd         (rd),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_valid    (o_valid),
        .out        (out),
        .o_overflow (o_overflow),
        .o_underflow(o_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW*NC-1:0] rep(input logic [BW-1:0] v);
        logic [BW*NC-1:0] r;
        for (int c = 0; c < NC; c++) r[c*BW +: BW] = v;
        return r;
    endfunction

    // Drive one cycle of stimulus. The model is updated from the pre-edge state,
    // and outputs are sampled 1 time unit after the edge.
    task automatic drive(input logic [NC-1:0] w, input logic [BW*NC-1:0] d, input logic r);
        bit vm;
        bit fullm [NC];
        vm = 1'b1;
        for (int c = 0; c < NC; c++) begin
            if (mq[c].size() == 0) vm = 1'b0;
            fullm[c] = (mq[c].size() == DEPTH);
        end
        wr = w; in = d; rd = r;
        if (r && vm) begin
            for (int c = 0; c < NC; c++) exp_row[c*BW +: BW] = mq[c].pop_front();
        end
        if (r && !vm) exp_udf = 1'b1;
        for (int c = 0; c < NC; c++) begin
            if (w[c]) begin
                if (fullm[c]) exp_ovf = 1'b1;
                else mq[c].push_back(d[c*BW +: BW]);
            end
        end
        @(posedge clk); #1;
        wr = '0; rd = 1'b0;
    endtask

    task automatic do_reset(input logic [NC-1:0] w);
        reset = 1'b0; wr = w; in = rep(32'hDEAD); rd = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; wr = '0; rd = 1'b0;
        for (int c = 0; c < NC; c++) mq[c].delete();
        exp_row = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset('0);
        tests++;
        if (o_full !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: full=%b ready=%b valid=%b, want 0 1 0", o_full, o_ready, o_valid);
        end
        tests++;
        if (out !== '0 || o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_regs: out=%h ovf=%b udf=%b, want 0 0 0", out, o_overflow, o_underflow);
        end
    endtask

    task automatic test_basic();
        logic [BW*NC-1:0] d;
        do_reset('0);
        for (int c = 0; c < NC; c++) d[c*BW +: BW] = 32'(100 + c);
        drive('1, d, 1'b0);
        tests++;
        if (o_valid !== 1'b1) begin
            fails++; $display("FAIL basic_valid: got %b want 1", o_valid);
        end
        drive('0, '0, 1'b1);
        for (int c = 0; c < NC; c++) begin
            tests++;
            if (out[c*BW +: BW] !== 32'(100 + c)) begin
                fails++; $display("FAIL basic_out col%0d: got %0d want %0d", c, out[c*BW +: BW], 100 + c);
            end
        end
        tests++;
        if (o_valid !== 1'b0 || out !== exp_row) begin
            fails++; $display("FAIL basic_after: valid=%b out=%h want 0 %h", o_valid, out, exp_row);
        end
    endtask

    task automatic test_skew();
        logic [BW*NC-1:0] d;
        do_reset('0);
        for (int k = 0; k < NC; k++) begin
            d = '0;
            d[k*BW +: BW] = 32'(8'hA0 + k);
            drive(NC'(1) << k, d, 1'b0);
            tests++;
            if (o_valid !== (k == NC-1)) begin
                fails++; $display("FAIL skew_valid k=%0d: got %b want %b", k, o_valid, (k == NC-1));
            end
        end
        drive('0, '0, 1'b1);
        tests++;
        if (out !== exp_row || out[7*BW +: BW] !== 32'hA7 || out[BW-1:0] !== 32'hA0) begin
            fails++; $display("FAIL skew_out: got %h want %h", out, exp_row);
        end
    endtask

    task automatic test_fill();
        logic [BW*NC-1:0] d;
        do_reset('0);
        for (int c = 0; c < NC; c++) d[c*BW +: BW] = 32'(1000 + c);
        d[BW-1:0] = 32'd0;
        drive('1, d, 1'b0);
        for (int v = 1; v < DEPTH; v++) drive(NC'(1), rep(32'(v)), 1'b0);
        tests++;
        if (o_full !== 1'b1 || o_ready !== 1'b0 || o_overflow !== 1'b0) begin
            fails++; $display("FAIL fill_full: full=%b ready=%b ovf=%b want 1 0 0", o_full, o_ready, o_overflow);
        end
        drive(NC'(1), rep(32'd999), 1'b0);
        tests++;
        if (o_overflow !== 1'b1 || o_overflow !== exp_ovf) begin
            fails++; $display("FAIL fill_overflow: got %b want 1", o_overflow);
        end
        for (int k = 1; k < DEPTH; k++) drive({{(NC-1){1'b1}}, 1'b0}, rep(32'(2000 + k)), 1'b0);
        for (int k = 0; k < DEPTH; k++) begin
            drive('0, '0, 1'b1);
            tests++;
            if (out !== exp_row) begin
                fails++; $display("FAIL fill_drain row%0d: got %h want %h", k, out, exp_row);
            end
        end
        tests++;
        if (out[BW-1:0] !== 32'd63 || o_valid !== 1'b0 || o_overflow !== 1'b1) begin
            fails++; $display("FAIL fill_last: col0=%0d valid=%b ovf=%b want 63 0 1", out[BW-1:0], o_valid, o_overflow);
        end
    endtask

    task automatic test_wrap();
        int bad;
        bad = 0;
        do_reset('0);
        for (int r = 0; r < 200; r++) begin
            drive('1, rep(32'(r)), 1'b0);
            drive('0, '0, 1'b1);
            tests++;
            if (out !== exp_row || out[BW-1:0] !== 32'(r)) begin
                fails++; bad++;
                if (bad < 5) $display("FAIL wrap_row%0d: got %h want %h", r, out, exp_row);
            end
        end
        tests++;
        if (o_overflow !== 1'b0 || o_underflow !== 1'b0 || o_valid !== 1'b0) begin
            fails++; $display("FAIL wrap_flags: ovf=%b udf=%b valid=%b want 0 0 0", o_overflow, o_underflow, o_valid);
        end
    endtask

    task automatic test_underflow();
        logic [BW*NC-1:0] z;
        do_reset('0);
        drive('1, rep(32'h11), 1'b0);
        drive('0, '0, 1'b1);
        drive(8'hF7, rep(32'h22), 1'b0);
        drive('0, '0, 1'b1);
        tests++;
        if (out !== rep(32'h11) || out !== exp_row || o_underflow !== 1'b1 || o_valid !== 1'b0) begin
            fails++; $display("FAIL underflow: out=%h udf=%b valid=%b want %h 1 0", out, o_underflow, o_valid, rep(32'h11));
        end
        z = '0;
        z[3*BW +: BW] = 32'h33;
        drive(8'h08, z, 1'b0);
        drive('0, '0, 1'b1);
        tests++;
        if (out !== exp_row || out[3*BW +: BW] !== 32'h33 || out[BW-1:0] !== 32'h22) begin
            fail_line("underflow_next", out, exp_row);
        end
    endtask

    task automatic fail_line(input string nm, input logic [BW*NC-1:0] got, input logic [BW*NC-1:0] want);
        fails++;
        $display("FAIL %s: got %h want %h", nm, got, want);
    endtask

    task automatic test_full_rw();
        do_reset('0);
        for (int r = 0; r < DEPTH; r++) drive('1, rep(32'(r + 5)), 1'b0);
        tests++;
        if (o_full !== 1'b1) begin
            fails++; $display("FAIL fullrw_full: got %b want 1", o_full);
        end
        drive('1, rep(32'hEE), 1'b1);
        tests++;
        if (out !== rep(32'd5) || out !== exp_row || o_overflow !== 1'b1 || o_full !== 1'b0) begin
            fails++; $display("FAIL fullrw_same: out=%h ovf=%b full=%b want %h 1 0", out, o_overflow, o_full, rep(32'd5));
        end
        for (int r = 1; r < DEPTH; r++) drive('0, '0, 1'b1);
        tests++;
        if (out !== rep(32'(DEPTH + 4)) || o_valid !== 1'b0) begin
            fails++; $display("FAIL fullrw_drain: out=%h valid=%b want %h 0", out, o_valid, rep(32'(DEPTH + 4)));
        end
    endtask

    task automatic test_reset_mid();
        do_reset('0);
        drive('0, '0, 1'b1);
        for (int r = 0; r < 10; r++) drive('1, rep(32'(r + 1)), 1'b0);
        drive('0, '0, 1'b1);
        do_reset('1);
        tests++;
        if (o_valid !== 1'b0 || o_full !== 1'b0 || out !== '0 || o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
            fails++; $display("FAIL resetmid_state: valid=%b full=%b out=%h ovf=%b udf=%b want 0 0 0 0 0",
                              o_valid, o_full, out, o_overflow, o_underflow);
        end
        drive('1, rep(32'h55), 1'b0);
        drive('0, '0, 1'b1);
        tests++;
        if (out !== rep(32'h55) || out !== exp_row || o_valid !== 1'b0) begin
            fails++; $display("FAIL resetmid_next: out=%h valid=%b want %h 0", out, o_valid, rep(32'h55));
        end
    endtask

    initial begin
        reset = 1'b0; wr = '0; rd = 1'b0; in = '0;
        exp_row = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_skew();
        test_fill();
        test_wrap();
        test_underflow();
        test_full_rw();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
